// File: rtl/or_gate_truth_checker.sv
// Self-running truth-table driver and checker for a 2-input OR gate.
// Sweeps {a,b} through 00,01,10,11, compares the returned gate output, and reports the results.
module or_gate_truth_checker #(
  parameter int HOLD_CYCLES = 4,
  parameter int SWEEPS      = 2,
  parameter int ERR_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             or_i,
  output logic             a_o,
  output logic             b_o,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [3:0]       err_vec,
  output logic [1:0]       vec_idx
);

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  localparam logic [7:0] HOLD_LAST  = 8'(HOLD_CYCLES - 1);
  localparam logic [3:0] SWEEP_LAST = 4'(SWEEPS - 1);

  state_t           state_q, state_d;
  logic             a_q, a_d;
  logic             b_q, b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [3:0]       err_vec_q, err_vec_d;
  logic [1:0]       vec_idx_q, vec_idx_d;
  logic [7:0]       hold_cnt_q, hold_cnt_d;
  logic [3:0]       sweep_cnt_q, sweep_cnt_d;
  logic             mismatch;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // The gate is combinational, so or_i reflects the registered a/b of this same cycle.
  assign mismatch = (or_i != (a_q | b_q));

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    err_cnt_d   = err_cnt_q;
    err_vec_d   = err_vec_q;
    vec_idx_d   = vec_idx_q;
    hold_cnt_d  = hold_cnt_q;
    sweep_cnt_d = sweep_cnt_q;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        a_d    = 1'b0;
        b_d    = 1'b0;
        if (start) begin
          state_d     = DRIVE;
          vec_idx_d   = 2'd0;
          hold_cnt_d  = 8'd0;
          sweep_cnt_d = 4'd0;
          err_cnt_d   = '0;
          err_vec_d   = 4'd0;
          pass_d      = 1'b0;
          busy_d      = 1'b1;
        end
      end

      DRIVE: begin
        if (hold_cnt_q == HOLD_LAST) begin
          if (mismatch) begin
            err_cnt_d            = sat_inc(err_cnt_q);
            err_vec_d[vec_idx_q] = 1'b1;
          end
          hold_cnt_d = 8'd0;
          vec_idx_d  = vec_idx_q + 2'd1;
          if (vec_idx_q == 2'd3) begin
            sweep_cnt_d = sweep_cnt_q + 4'd1;
          end
          if ((vec_idx_q == 2'd3) && (sweep_cnt_q == SWEEP_LAST)) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            a_d     = 1'b0;
            b_d     = 1'b0;
            // err_cnt_d already includes the final compare.
            pass_d  = (err_cnt_d == '0);
          end else begin
            a_d = vec_idx_d[1];
            b_d = vec_idx_d[0];
          end
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        a_d     = 1'b0;
        b_d     = 1'b0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_cnt_q   <= '0;
      err_vec_q   <= 4'd0;
      vec_idx_q   <= 2'd0;
      hold_cnt_q  <= 8'd0;
      sweep_cnt_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_cnt_q   <= err_cnt_d;
      err_vec_q   <= err_vec_d;
      vec_idx_q   <= vec_idx_d;
      hold_cnt_q  <= hold_cnt_d;
      sweep_cnt_q <= sweep_cnt_d;
    end
  end

  assign a_o     = a_q;
  assign b_o     = b_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign err_cnt = err_cnt_q;
  assign err_vec = err_vec_q;
  assign vec_idx = vec_idx_q;

endmodule
